// File: rtl/nw_align_emitter.sv
`default_nettype none
// ============================================================================
//  Module   : nw_align_emitter
//  Purpose  : Turns the Needleman-Wunsch traceback coordinate stream
//             ((LENGTH-1,LENGTH-1) down to (0,0)) into alignment columns
//             (character pair + gap flags), emitted end-to-start, while
//             accumulating score, match, gap and column counts on consumption.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset          clock, synchronous active-high reset
//    s1, s2              packed strings, char i at [((LENGTH-1)-i)*CWIDTH +: CWIDTH]
//    in_valid/in_ready   coordinate handshake, in_x (column) / in_y (row)
//    col_valid/col_ready column handshake
//    col_c1, col_c2      column characters (0 on the gapped side)
//    col_gap1, col_gap2  gap in s1 / gap in s2
//    col_match, col_last equal diagonal / the (0,0) column
//    done                final column consumed (sticky until reset)
//    aln_score           signed running score (wraps at SWIDTH)
//    match_cnt, gap_cnt, col_cnt   consumed-column counters
//    err                 sticky path error (only with NW_ALIGN_PATH_CHECK_EN)
//  Build option
//    NW_ALIGN_PATH_CHECK_EN : adds path checking and the err output.
// ============================================================================
module nw_align_emitter #(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int SWIDTH      = 16,
    parameter int CORD_LENGTH = 8,
    parameter int MATCH       = 1,
    parameter int MISMATCH    = -1,
    parameter int INDEL       = -1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LENGTH*CWIDTH-1:0] s1,
    input  logic [LENGTH*CWIDTH-1:0] s2,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CORD_LENGTH-1:0]   in_x,
    input  logic [CORD_LENGTH-1:0]   in_y,
    output logic                     col_valid,
    input  logic                     col_ready,
    output logic [CWIDTH-1:0]        col_c1,
    output logic [CWIDTH-1:0]        col_c2,
    output logic                     col_gap1,
    output logic                     col_gap2,
    output logic                     col_match,
    output logic                     col_last,
    output logic                     done,
    output logic [SWIDTH-1:0]        aln_score,
    output logic [CORD_LENGTH:0]     match_cnt,
    output logic [CORD_LENGTH:0]     gap_cnt,
    output logic [CORD_LENGTH:0]     col_cnt
`ifdef NW_ALIGN_PATH_CHECK_EN
    ,
    output logic                     err
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HOLD  = 3'd1,
        ST_LAST  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [CORD_LENGTH:0] c_cnt_one = (CORD_LENGTH+1)'(1);
    localparam logic [SWIDTH-1:0]    c_match   = SWIDTH'(MATCH);
    localparam logic [SWIDTH-1:0]    c_mism    = SWIDTH'(MISMATCH);
    localparam logic [SWIDTH-1:0]    c_indel   = SWIDTH'(INDEL);

    state_t                  r_state, w_next;
    logic [CORD_LENGTH-1:0]  r_hx, r_hy;
    logic                    w_slot_free, w_consume, w_accept, w_bad;
    logic                    w_take, w_load, w_load_last;
    logic                    w_vert, w_horz, w_is_origin;
    logic [CWIDTH-1:0]       w_c1, w_c2;

    // Character i of a packed string; indices outside the string read as 0.
    function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] s,
                                                  input logic [CORD_LENGTH-1:0]   idx);
        char_at = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (idx == CORD_LENGTH'(i))
                char_at = s[((LENGTH-1)-i)*CWIDTH +: CWIDTH];
        end
    endfunction

    assign w_slot_free = !col_valid || col_ready;
    assign w_consume   = col_valid && col_ready;
    assign w_is_origin = (in_x == '0) && (in_y == '0);
    assign w_c1        = char_at(s1, r_hy);
    assign w_c2        = char_at(s2, r_hx);
    // The (0,0) column is always diagonal, so classification is bypassed then.
    assign w_vert      = !w_load_last && (in_x == r_hx) && (in_y < r_hy);
    assign w_horz      = !w_load_last && (in_y == r_hy) && (in_x < r_hx);
    assign done        = (r_state == ST_DONE);

`ifdef NW_ALIGN_PATH_CHECK_EN
    localparam logic [CORD_LENGTH:0]   c_len     = (CORD_LENGTH+1)'(LENGTH);
    localparam logic [CORD_LENGTH-1:0] c_top     = CORD_LENGTH'(LENGTH-1);
    localparam logic [CORD_LENGTH-1:0] c_maxstep = CORD_LENGTH'(1);
    logic r_err;

    assign err = r_err;

    always_comb begin
        w_bad = 1'b0;
        if (({1'b0, in_x} >= c_len) || ({1'b0, in_y} >= c_len))
            w_bad = 1'b1;
        else if (r_state == ST_IDLE)
            w_bad = (in_x != c_top) || (in_y != c_top);
        else if ((in_x >= r_hx) && (in_y >= r_hy))
            w_bad = 1'b1;
        else if (((in_x < r_hx) && ((r_hx - in_x) > c_maxstep)) ||
                 ((in_y < r_hy) && ((r_hy - in_y) > c_maxstep)))
            w_bad = 1'b1;
    end
`else
    assign w_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        in_ready    = 1'b0;
        w_accept    = 1'b0;
        w_take      = 1'b0;
        w_load      = 1'b0;
        w_load_last = 1'b0;
        case (r_state)
            ST_IDLE: in_ready = 1'b1;
            ST_HOLD: in_ready = w_slot_free;
            default: in_ready = 1'b0;
        endcase
`ifdef NW_ALIGN_PATH_CHECK_EN
        if (r_err) in_ready = 1'b0;
`endif
        w_accept = in_valid && in_ready;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_bad) begin
                    w_take = 1'b1;
                    w_next = w_is_origin ? ST_LAST : ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The incoming coordinate resolves the direction of the held cell.
                if (w_accept && !w_bad) begin
                    w_take = 1'b1;
                    w_load = 1'b1;
                    w_next = w_is_origin ? ST_LAST : ST_HOLD;
                end
            end
            ST_LAST: begin
                if (w_slot_free) begin
                    w_load_last = 1'b1;
                    w_next      = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_consume) w_next = ST_DONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hx      <= '0;
            r_hy      <= '0;
            col_valid <= 1'b0;
            col_c1    <= '0;
            col_c2    <= '0;
            col_gap1  <= 1'b0;
            col_gap2  <= 1'b0;
            col_match <= 1'b0;
            col_last  <= 1'b0;
            aln_score <= '0;
            match_cnt <= '0;
            gap_cnt   <= '0;
            col_cnt   <= '0;
`ifdef NW_ALIGN_PATH_CHECK_EN
            r_err     <= 1'b0;
`endif
        end else begin
            if (w_take) begin
                r_hx <= in_x;
                r_hy <= in_y;
            end
            if (w_load || w_load_last) begin
                col_valid <= 1'b1;
                col_last  <= w_load_last;
                col_gap1  <= w_horz;
                col_gap2  <= w_vert;
                col_c1    <= w_horz ? '0 : w_c1;
                col_c2    <= w_vert ? '0 : w_c2;
                col_match <= !w_horz && !w_vert && (w_c1 == w_c2);
            end else if (w_consume) begin
                col_valid <= 1'b0;
            end
            if (w_consume) begin
                col_cnt <= col_cnt + c_cnt_one;
                if (col_gap1 || col_gap2) begin
                    gap_cnt   <= gap_cnt + c_cnt_one;
                    aln_score <= aln_score + c_indel;
                end else if (col_match) begin
                    match_cnt <= match_cnt + c_cnt_one;
                    aln_score <= aln_score + c_match;
                end else begin
                    aln_score <= aln_score + c_mism;
                end
            end
`ifdef NW_ALIGN_PATH_CHECK_EN
            if (w_accept && w_bad) r_err <= 1'b1;
`endif
        end
    end

endmodule
`default_nettype wire

// File: doc/nw_align_emitter.md
Name: nw_align_emitter

Overview:
- Consumes the traceback coordinate stream produced after the Needleman-Wunsch grid finishes, ordered from (LENGTH-1, LENGTH-1) down to (0,0).
- Converts the stream into alignment columns: character pairs with gap flags, emitted end-to-start.
- Accumulates the alignment score and match/gap counts so the result can be cross-checked against the grid score.
- Sits between the grid traceback and the downstream host/result writer.

Parameters:
- LENGTH, 10, characters per string.
- CWIDTH, 2, bits per character.
- SWIDTH, 16, bits per signed score.
- CORD_LENGTH, 8, bits per coordinate; counters are CORD_LENGTH+1 bits.
- MATCH, 1, signed weight for an equal-character diagonal column.
- MISMATCH, -1, signed weight for an unequal diagonal column.
- INDEL, -1, signed weight for a gap column.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s1  in  LENGTH*CWIDTH  row string; char i = s1[((LENGTH-1)-i)*CWIDTH +: CWIDTH]; indexed by y.
- s2  in  LENGTH*CWIDTH  column string; same packing; indexed by x.
- in_valid  in  1  coordinate present.
- in_ready  out  1  coordinate accepted when in_valid && in_ready.
- in_x  in  CORD_LENGTH  column coordinate.
- in_y  in  CORD_LENGTH  row coordinate.
- col_valid  out  1  column present.
- col_ready  in  1  column consumed when col_valid && col_ready.
- col_c1  out  CWIDTH  s1 character (0 when col_gap1).
- col_c2  out  CWIDTH  s2 character (0 when col_gap2).
- col_gap1  out  1  gap in s1.
- col_gap2  out  1  gap in s2.
- col_match  out  1  diagonal column with equal characters.
- col_last  out  1  final column (the (0,0) cell).
- done  out  1  final column consumed; held until reset.
- aln_score  out  SWIDTH  signed running score.
- match_cnt  out  CORD_LENGTH+1  consumed match columns.
- gap_cnt  out  CORD_LENGTH+1  consumed gap columns.
- col_cnt  out  CORD_LENGTH+1  consumed columns.

Behaviour:
- Reset (synchronous, active-high): state IDLE; every output 0, except in_ready=1 in IDLE. Reset mid-stream discards the held coordinate and any pending column.
- Output slot is a single register. A slot is "free" when !col_valid || col_ready.
- Classification of held cell (hx,hy) against next coordinate (nx,ny):
  - y decreased, x unchanged → vertical: c1=s1[hy], gap2=1.
  - x decreased, y unchanged → horizontal: c2=s2[hx], gap1=1.
  - otherwise → diagonal: c1=s1[hy], c2=s2[hx], match=(c1==c2).
- The (0,0) cell always produces a diagonal column with col_last=1.
- States:
  - IDLE: in_ready=1. On accept, hold the coordinate. If it is (0,0), go LAST; else go HOLD.
  - HOLD: in_ready = slot free. On accept, load the column for the held cell into the slot, then hold the new coordinate. If the new coordinate is (0,0), go LAST; else stay in HOLD.
  - LAST: in_ready=0. When the slot is free, load the (0,0) column and go DRAIN.
  - DRAIN: in_ready=0. When the last column is consumed, go DONE.
  - DONE: in_ready=0, done=1, col_valid=0. Stays here until reset.
- Latency: a column appears on the cycle after the coordinate that resolves it is accepted. Full throughput is one column per cycle when col_ready=1.
- Backpressure: while col_valid && !col_ready, every col_* output is held stable and no coordinate is accepted in HOLD.
- Counters and score update only on column consumption (col_valid && col_ready):
  - col_cnt +1.
  - gap column: gap_cnt +1, aln_score += INDEL.
  - diagonal match: match_cnt +1, aln_score += MATCH.
  - diagonal mismatch: aln_score += MISMATCH.
- aln_score is two's-complement wrapping at SWIDTH. Counters never exceed 2*LENGTH-1.
- in_x / in_y are sampled only on accept; values outside the handshake are ignored.

Optional Feature:
- Macro: NW_ALIGN_PATH_CHECK_EN.
- Enabled: adds output err (1 bit, reset 0, sticky).
- err is set on any of these:
  - first coordinate is not (LENGTH-1, LENGTH-1);
  - a step where neither coordinate decreased;
  - a decrease greater than 1;
  - a coordinate ≥ LENGTH.
- The offending coordinate produces no column. in_ready is forced to 0 until reset, and done never asserts.
- Disabled: no err port. No checking is performed; any non-vertical, non-horizontal step is treated as diagonal.

Test Plan:
- LENGTH=4, CWIDTH=2, s1=s2=8'h1B; path (3,3),(2,2),(1,1),(0,0), col_ready=1 → 4 diagonal matches with c1=c2 = 3,2,1,0; col_last on the 4th; aln_score=4, match_cnt=4, gap_cnt=0, done=1.
- Same strings; path (3,3),(3,2),(2,1),(1,0),(0,0) → 5 columns:
  - gap2 with c1=3;
  - diagonal 2/3 mismatch;
  - diagonal 1/2 mismatch;
  - gap1 with c2=1;
  - diagonal 0/0 match, last.
  - Totals: aln_score=-3, gap_cnt=2, match_cnt=1, col_cnt=5.
- Case 1 with col_ready held low for 3 cycles after the first column → column stable, in_ready=0 in HOLD, no column lost or duplicated; final counts identical to case 1.
- Reset asserted after the second column is consumed, then case 1 replayed → outputs zero the cycle after reset, and the replay yields exactly case 1 results.
- Path (3,3),(1,1): macro enabled → err=1, in_ready=0, no column for (3,3); macro disabled → one diagonal column (c1=3, c2=3, match).
- LENGTH=1, single coordinate (0,0) → one diagonal column with last=1, col_cnt=1, done=1.
